// File: rtl/frame_readout_pkg.sv
// Shared types and default constants for the frame readout controller.
package frame_readout_pkg;

    localparam int         FRAME_WORDS_DEF = 8;
    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA6;
    localparam int         TIMEOUT_DEF     = 15;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        REQ,
        WAIT,
        LO,
        HI,
        FLUSH
    } state_e;

endpackage

// File: rtl/frame_readout_ctl.sv
// Pulls 16-bit words from an upstream frame buffer and serialises them as a
// sync byte followed by little-endian byte pairs; overflows flush the frame.
module frame_readout_ctl
    import frame_readout_pkg::*;
#(
    parameter int         FRAME_WORDS = FRAME_WORDS_DEF,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT     = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        FrameReady,
    input  logic        DataReady,
    input  logic [15:0] DataVal,
    input  logic        DataOverf,
    output logic        DataNext,
    output logic        DataFrameReset,
    output logic [7:0]  TxByte,
    output logic        TxValid,
    input  logic        TxReady,
    output logic [7:0]  LostFrames,
    output logic        Busy,
    output state_e      dbg_state_o
);

    localparam logic [7:0] LAST_WORD  = 8'(FRAME_WORDS - 1);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    // Downstream handshake: a byte transfers on a rising edge where TxValid and
    // TxReady are both high; once TxValid rises, TxByte/TxValid hold until then.

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  timer_q, timer_d;
    logic [15:0] hold_q, hold_d;
    logic        pend_q, pend_d;
    logic [7:0]  lost_q, lost_d;

    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        data_next_q, data_next_d;
    logic        frame_rst_q, frame_rst_d;
    logic        busy_q, busy_d;
    logic        overf_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            timer_q     <= '0;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            lost_q      <= '0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= '0;
            data_next_q <= 1'b0;
            frame_rst_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            lost_q      <= lost_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            data_next_q <= data_next_d;
            frame_rst_q <= frame_rst_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        hold_d    = hold_q;
        pend_d    = pend_q;
        lost_d    = lost_q;
        // An overflow seen during a byte may only act once that byte is taken.
        overf_eff = pend_q | DataOverf;
        case (state_q)
            IDLE: begin
                if (DataOverf) state_d = FLUSH;
                else if (FrameReady) state_d = HDR;
            end
            HDR, LO: begin
                if (TxReady) begin
                    pend_d  = 1'b0;
                    state_d = overf_eff ? FLUSH : ((state_q == HDR) ? REQ : HI);
                end else if (DataOverf) begin
                    pend_d = 1'b1;
                end
            end
            HI: begin
                if (TxReady) begin
                    pend_d = 1'b0;
                    if (overf_eff) begin
                        state_d = FLUSH;
                    end else if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = REQ;
                    end
                end else if (DataOverf) begin
                    pend_d = 1'b1;
                end
            end
            REQ: begin
                timer_d = '0;
                state_d = DataOverf ? FLUSH : WAIT;
            end
            WAIT: begin
                if (DataOverf) begin
                    state_d = FLUSH;
                end else if (DataReady) begin
                    hold_d  = DataVal;
                    state_d = LO;
                end else begin
                    timer_d = timer_q + 8'd1;
                    if (timer_q == TIMER_LAST) state_d = FLUSH;
                end
            end
            FLUSH: begin
                lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
                cnt_d   = '0;
                timer_d = '0;
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        tx_valid_d  = 1'b0;
        tx_byte_d   = '0;
        data_next_d = 1'b0;
        frame_rst_d = 1'b0;
        busy_d      = (state_d != IDLE);
        case (state_d)
            HDR: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = SYNC_BYTE;
            end
            LO: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = hold_d[7:0];
            end
            HI: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = hold_d[15:8];
            end
            REQ:     data_next_d = 1'b1;
            FLUSH:   frame_rst_d = 1'b1;
            default: ;
        endcase
    end

    assign TxValid        = tx_valid_q;
    assign TxByte         = tx_byte_q;
    assign DataNext       = data_next_q;
    assign DataFrameReset = frame_rst_q;
    assign Busy           = busy_q;
    assign LostFrames     = lost_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_frame_readout_ctl.sv
// Randomised scoreboard bench for frame_readout_ctl with a behavioural
// upstream model and a byte-stream monitor.
module tb_frame_readout_ctl;
    import frame_readout_pkg::*;

    localparam int         FW   = 2;
    localparam logic [7:0] SYNC = 8'hA6;

    logic        clk = 1'b0;
    logic        rst;
    logic        FrameReady;
    logic        DataReady;
    logic [15:0] DataVal;
    logic        DataOverf;
    logic        DataNext;
    logic        DataFrameReset;
    logic [7:0]  TxByte;
    logic        TxValid;
    logic        TxReady = 1'b0;
    logic [7:0]  LostFrames;
    logic        Busy;
    state_e      dbg_state;

    frame_readout_ctl #(.FRAME_WORDS(FW), .SYNC_BYTE(SYNC), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .FrameReady(FrameReady), .DataReady(DataReady),
        .DataVal(DataVal), .DataOverf(DataOverf), .DataNext(DataNext),
        .DataFrameReset(DataFrameReset), .TxByte(TxByte), .TxValid(TxValid),
        .TxReady(TxReady), .LostFrames(LostFrames), .Busy(Busy),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] fixed_q[$];
    int          lost_exp = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", tag, act, req);
        end
    endtask

    // Upstream frame buffer: answers each DataNext after a random delay.
    int          resp_en = 1;
    int          resp_max_delay = 0;
    logic [15:0] resp_v;
    int          resp_d;
    always begin
        @(negedge clk);
        if (DataNext && resp_en != 0) begin
            resp_v = (fixed_q.size() != 0) ? fixed_q.pop_front() : 16'($urandom);
            exp_q.push_back(resp_v[7:0]);
            exp_q.push_back(resp_v[15:8]);
            resp_d = $urandom_range(0, resp_max_delay);
            repeat (resp_d + 1) @(negedge clk);
            DataVal   = resp_v;
            DataReady = 1'b1;
            @(negedge clk);
            DataReady = 1'b0;
        end
    end

    // Downstream sink and monitor: drives TxReady, pops expected bytes.
    int         ready_mode = 0;
    int         accepted_n = 0;
    int         stall_at = -1;
    int         stall_left = 0;
    int         frst_n = 0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_byte = '0;
    logic       rst_seen = 1'b1;
    logic       rdy;

    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        if (DataFrameReset) frst_n++;
        if (hold_pend && !rst_seen) begin
            chk("hold_valid", 32'(TxValid), 32'd1);
            chk("hold_byte", 32'(TxByte), 32'(hold_byte));
        end
        if (stall_left > 0 && TxValid && accepted_n == stall_at) begin
            rdy = 1'b0;
            stall_left--;
            if (exp_q.size() != 0) chk("stall_byte", 32'(TxByte), 32'(exp_q[0]));
        end else begin
            rdy = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        TxReady = rdy;
        if (TxValid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got %0h required none", TxByte);
            end else begin
                chk("tx_byte", 32'(TxByte), 32'(exp_q.pop_front()));
            end
            accepted_n++;
            hold_pend = 1'b0;
        end else begin
            hold_pend = TxValid;
            hold_byte = TxByte;
        end
    end

    task automatic start_frame();
        exp_q.push_back(SYNC);
        FrameReady = 1'b1;
        @(negedge clk);
        FrameReady = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (Busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(Busy), 32'd0);
    endtask

    task automatic bump_lost();
        lost_exp = (lost_exp >= 255) ? 255 : lost_exp + 1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(TxValid), 32'd0);
        chk({tag, "_byte"}, 32'(TxByte), 32'd0);
        chk({tag, "_next"}, 32'(DataNext), 32'd0);
        chk({tag, "_frst"}, 32'(DataFrameReset), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        int n;
        int a0;
        int p0;
        rst = 1'b1;
        FrameReady = 1'b0;
        DataReady = 1'b0;
        DataVal = '0;
        DataOverf = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_lost", 32'(LostFrames), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic two-word frame with immediate responses.
        fixed_q = {16'h1234, 16'hABCD};
        a0 = accepted_n;
        FrameReady = 1'b1;
        exp_q.push_back(SYNC);
        @(negedge clk);
        FrameReady = 1'b0;
        chk("hdr_latency_valid", 32'(TxValid), 32'd1);
        chk("hdr_latency_byte", 32'(TxByte), 32'(SYNC));
        wait_idle("basic_idle");
        chk("basic_bytes", 32'(accepted_n - a0), 32'd5);
        chk("basic_exp_left", 32'(exp_q.size()), 32'd0);
        chk("basic_lost", 32'(LostFrames), 32'd0);

        // Five-cycle backpressure on the first low byte.
        a0 = accepted_n;
        stall_at = accepted_n + 1;
        stall_left = 5;
        start_frame();
        wait_idle("stall_idle");
        chk("stall_done", 32'(stall_left), 32'd0);
        chk("stall_bytes", 32'(accepted_n - a0), 32'd5);
        chk("stall_exp_left", 32'(exp_q.size()), 32'd0);

        // Upstream never answers: timeout flush.
        resp_en = 0;
        p0 = frst_n;
        start_frame();
        n = 0;
        while (!DataNext && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_datanext_seen", 32'(DataNext), 32'd1);
        n = 0;
        while (!DataFrameReset && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd16);
        wait_idle("timeout_idle");
        bump_lost();
        chk("timeout_lost", 32'(LostFrames), 32'(lost_exp));
        chk("timeout_pulses", 32'(frst_n - p0), 32'd1);
        chk("timeout_exp_left", 32'(exp_q.size()), 32'd0);
        resp_en = 1;

        // Overflow while the low byte is stalled.
        a0 = accepted_n;
        p0 = frst_n;
        stall_at = accepted_n + 1;
        stall_left = 3;
        start_frame();
        n = 0;
        while (dbg_state != LO && n < 40) begin
            @(negedge clk);
            n++;
        end
        DataOverf = 1'b1;
        @(negedge clk);
        DataOverf = 1'b0;
        wait_idle("ovf_lo_idle");
        bump_lost();
        chk("ovf_lo_bytes", 32'(accepted_n - a0), 32'd2);
        chk("ovf_lo_hi_unsent", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        chk("ovf_lo_pulses", 32'(frst_n - p0), 32'd1);
        chk("ovf_lo_lost", 32'(LostFrames), 32'(lost_exp));

        // Overflow and FrameReady together in IDLE.
        a0 = accepted_n;
        FrameReady = 1'b1;
        DataOverf = 1'b1;
        @(negedge clk);
        FrameReady = 1'b0;
        DataOverf = 1'b0;
        chk("ovf_idle_frst", 32'(DataFrameReset), 32'd1);
        chk("ovf_idle_novalid", 32'(TxValid), 32'd0);
        wait_idle("ovf_idle_idle");
        bump_lost();
        chk("ovf_idle_lost", 32'(LostFrames), 32'(lost_exp));
        chk("ovf_idle_bytes", 32'(accepted_n - a0), 32'd0);

        // Random frames with random backpressure and response delays.
        ready_mode = 1;
        resp_max_delay = 3;
        for (int f = 0; f < 25; f++) begin
            a0 = accepted_n;
            start_frame();
            wait_idle("rand_idle");
            chk("rand_bytes", 32'(accepted_n - a0), 32'(1 + 2 * FW));
            chk("rand_exp_left", 32'(exp_q.size()), 32'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        ready_mode = 0;

        // Saturation of the lost-frame counter.
        p0 = frst_n;
        for (int k = 0; k < 300; k++) begin
            DataOverf = 1'b1;
            @(negedge clk);
            DataOverf = 1'b0;
            @(negedge clk);
            @(negedge clk);
            bump_lost();
        end
        chk("sat_lost", 32'(LostFrames), 32'(lost_exp));
        chk("sat_lost_255", 32'(LostFrames), 32'd255);
        chk("sat_pulses", 32'(frst_n - p0), 32'd300);

        // Reset while the high byte is presented.
        stall_at = accepted_n + 2;
        stall_left = 100;
        start_frame();
        n = 0;
        while (dbg_state != HI && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_hi_valid_before", 32'(TxValid), 32'd1);
        p0 = frst_n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rst_hi");
        chk("rst_hi_lost", 32'(LostFrames), 32'd0);
        stall_left = 0;
        exp_q.delete();
        lost_exp = 0;
        repeat (3) @(negedge clk);
        chk("rst_hi_no_frst", 32'(frst_n - p0), 32'd0);

        // Recovery frame after reset.
        a0 = accepted_n;
        start_frame();
        wait_idle("recover_idle");
        chk("recover_bytes", 32'(accepted_n - a0), 32'(1 + 2 * FW));
        chk("recover_exp_left", 32'(exp_q.size()), 32'd0);
        chk("recover_lost", 32'(LostFrames), 32'(lost_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/frame_readout_ctl.md
FRAME_READOUT_CTL -- requirements
Module: frame_readout_ctl

Interface
REQ-001 The block SHALL have parameter FRAME_WORDS, default 8, giving the 16-bit elements per frame (2..255).
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA6, giving the header byte emitted before each frame.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, giving the max cycles waited for DataReady after DataNext.
REQ-004 The block SHALL have port clk, input, 1, system clock; the single clock, with every output registered on rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port FrameReady, input, 1, a complete frame is available upstream.
REQ-007 The block SHALL have port DataReady, input, 1, DataVal holds the requested element.
REQ-008 The block SHALL have port DataVal, input, 16, the upstream element value.
REQ-009 The block SHALL have port DataOverf, input, 1, upstream buffer overflow.
REQ-010 The block SHALL have port DataNext, output, 1, a one-cycle request for the next element.
REQ-011 The block SHALL have port DataFrameReset, output, 1, a one-cycle pulse that restarts the upstream frame.
REQ-012 The block SHALL have port TxByte, output, 8, the downstream byte.
REQ-013 The block SHALL have port TxValid, output, 1, meaning TxByte is valid.
REQ-014 The block SHALL have port TxReady, input, 1, meaning downstream accepts TxByte this cycle.
REQ-015 The block SHALL have port LostFrames, output, 8, a saturating count of flushed frames.
REQ-016 The block SHALL have port Busy, output, 1, high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, HDR, REQ, WAIT, LO, HI, FLUSH.
REQ-018 IDLE: DataOverf=1 SHALL transition to FLUSH; otherwise FrameReady=1 SHALL transition to HDR; DataOverf takes priority when both are high.
REQ-019 HDR: TxByte=SYNC_BYTE and TxValid=1; TxReady=1 SHALL transition to REQ.
REQ-020 REQ: DataNext=1 for exactly this one cycle, wait timer cleared, then transition to WAIT.
REQ-021 WAIT: DataReady=1 SHALL capture DataVal into a 16-bit hold register and transition to LO.
REQ-022 WAIT: each cycle without DataReady SHALL increment the timer; the timer reaching TIMEOUT SHALL transition to FLUSH.
REQ-023 LO: TxByte=hold[7:0] and TxValid=1; TxReady=1 SHALL transition to HI.
REQ-024 HI: TxByte=hold[15:8] and TxValid=1; on TxReady=1, the last word (count==FRAME_WORDS-1) SHALL transition to IDLE, otherwise count increments and the FSM goes to REQ.
REQ-025 FLUSH: DataFrameReset=1 for one cycle, LostFrames increments saturating at 255, word count clears, then transition to IDLE.
REQ-026 Once TxValid is asserted, TxValid and TxByte SHALL hold stable until TxReady=1; no abort is permitted mid-byte.
REQ-027 DataOverf=1 in HDR, LO or HI SHALL set a pending flag; at the next byte acceptance the FSM SHALL go to FLUSH instead of its normal successor, and the flag SHALL clear.
REQ-028 DataOverf=1 in REQ or WAIT SHALL transition to FLUSH at the next edge, with priority over DataReady.
REQ-029 Latency: FrameReady sampled high in IDLE SHALL produce TxValid with SYNC_BYTE on the next cycle.
REQ-030 A complete frame SHALL emit exactly 1+2*FRAME_WORDS bytes: header, then each word low byte first.
REQ-031 DataNext SHALL never be asserted outside REQ, and DataFrameReset SHALL never be asserted outside FLUSH.
REQ-032 Word count width SHALL be 8 bits and SHALL wrap to 0 on frame completion.

Reset
REQ-033 rst=1 SHALL force IDLE and clear count, timer, hold, pending flag and LostFrames, with all outputs 0, regardless of state, including mid-byte with TxValid high.
REQ-034 Reset SHALL NOT pulse DataFrameReset.

Structure
REQ-035 The package frame_readout_pkg SHALL hold the state enum and the default constants FRAME_WORDS_DEF, SYNC_BYTE_DEF and TIMEOUT_DEF.
REQ-036 The implementation SHALL be a single module with no sub-modules; the timer and counters SHALL be inline.

Verification
REQ-037 FRAME_WORDS=2, TxReady=1, FrameReady pulse, DataReady one cycle after each DataNext with values 16'h1234 and 16'hABCD -> bytes A6,34,12,CD,AB; Busy low afterwards; LostFrames=0.
REQ-038 TxReady held 0 for 5 cycles in LO -> TxValid=1 with TxByte constant for all 5 cycles; the frame then completes unchanged.
REQ-039 DataReady never asserted -> after 15 wait cycles, a single DataFrameReset pulse; LostFrames=1; back to IDLE.
REQ-040 DataOverf pulsed in LO with TxReady=0 -> the low byte still completes, then FLUSH, and LostFrames increments; DataOverf together with FrameReady in IDLE -> FLUSH, with no header emitted.
REQ-041 300 forced flushes -> LostFrames saturates at 255.
REQ-042 rst asserted in HI with TxValid=1 -> next cycle all outputs 0, IDLE, and no DataFrameReset pulse.
